// File: rtl/gelato_issue_arbiter_pkg.sv
// gelato_issue_pkg: shared sizes, issue-slot types and round-robin helper for the issue arbiter
package gelato_issue_pkg;

    localparam int NUM_ISSUE_QUEUES = 4;
    localparam int ISSUE_DATA_WIDTH = 32;
    localparam int ISSUE_QID_WIDTH  = $clog2(NUM_ISSUE_QUEUES);

    typedef logic [ISSUE_QID_WIDTH-1:0] issue_qid_t;

    typedef struct packed {
        issue_qid_t                  qid;
        logic [ISSUE_DATA_WIDTH-1:0] data;
    } issue_entry_t;

    function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gelato_issue_arbiter_if.sv
// gelato_issue_arbiter_if: upstream queue signals plus the issue-slot handshake
interface gelato_issue_arbiter_if
    import gelato_issue_pkg::*;
#(
    parameter int NUM_QUEUES = NUM_ISSUE_QUEUES,
    parameter int DATA_WIDTH = ISSUE_DATA_WIDTH,
    parameter int QID_WIDTH  = $clog2(NUM_QUEUES)
);
    logic                             rdy;
    logic                             flush;
    logic [NUM_QUEUES-1:0]            q_empty;
    logic [NUM_QUEUES*DATA_WIDTH-1:0] q_tail_data;
    logic [NUM_QUEUES-1:0]            q_blocked;
    logic [NUM_QUEUES-1:0]            q_pop;
    logic                             issue_valid;
    logic [DATA_WIDTH-1:0]            issue_data;
    logic [QID_WIDTH-1:0]             issue_qid;
    logic                             issue_ready;
    logic [31:0]                      issue_count;

    modport master (
        input  rdy, flush, q_empty, q_tail_data, q_blocked, issue_ready,
        output q_pop, issue_valid, issue_data, issue_qid, issue_count
    );

    modport slave (
        output rdy, flush, q_empty, q_tail_data, q_blocked, issue_ready,
        input  q_pop, issue_valid, issue_data, issue_qid, issue_count
    );
endinterface

// File: rtl/gelato_issue_arbiter_picker.sv
// gelato_rr_picker: round-robin grant as a priority scan over the request vector doubled end to end
module gelato_rr_picker #(
    parameter int N  = 4,
    parameter int QW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [QW-1:0] ptr_i,
    output logic [N-1:0]  gnt_onehot_o,
    output logic [QW-1:0] gnt_idx_o,
    output logic          any_o
);
    localparam int IW = $clog2(2 * N);

    logic [2*N-1:0] dbl;

    assign dbl = {req_i, req_i};

    // scan from the far end down so the request closest to ptr wins
    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (dbl[IW'(int'(ptr_i) + j)]) begin
                any_o     = 1'b1;
                gnt_idx_o = QW'((int'(ptr_i) + j) % N);
            end
        end
        gnt_onehot_o = any_o ? (N'(1) << gnt_idx_o) : '0;
    end
endmodule

// File: rtl/gelato_issue_arbiter.sv
// gelato_issue_arbiter: round-robin pop of per-warp queues into one registered issue slot
module gelato_issue_arbiter
    import gelato_issue_pkg::*;
#(
    parameter int NUM_QUEUES = NUM_ISSUE_QUEUES,
    parameter int DATA_WIDTH = ISSUE_DATA_WIDTH,
    parameter int QID_WIDTH  = $clog2(NUM_QUEUES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gelato_issue_arbiter_if.master bus
);
    typedef struct packed {
        logic                  valid;
        logic [QID_WIDTH-1:0]  qid;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    slot_t                 slot_q, slot_d;
    logic [QID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]           count_q, count_d;
    logic [NUM_QUEUES-1:0] eligible, gnt_onehot;
    logic [QID_WIDTH-1:0]  gnt_idx;
    logic                  any_eligible, can_load, load;
    logic [DATA_WIDTH-1:0] tails [NUM_QUEUES];

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_tail
        assign tails[g] = bus.q_tail_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign eligible = ~bus.q_empty & ~bus.q_blocked;

    gelato_rr_picker #(.N(NUM_QUEUES), .QW(QID_WIDTH)) u_picker (
        .req_i        (eligible),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .any_o        (any_eligible)
    );

    assign can_load = bus.rdy && !bus.flush && (!slot_q.valid || bus.issue_ready);
    assign load     = can_load && any_eligible;

    assign bus.q_pop       = (load && rst_n) ? gnt_onehot : '0;
    assign bus.issue_valid = slot_q.valid;
    assign bus.issue_data  = slot_q.data;
    assign bus.issue_qid   = slot_q.qid;
    assign bus.issue_count = count_q;

    // load wins over drain; flush or an accepted/empty slot with nothing to load empties it
    always_comb begin
        slot_d   = slot_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        if (load) begin
            slot_d   = '{valid: 1'b1, qid: gnt_idx, data: tails[gnt_idx]};
            rr_ptr_d = QID_WIDTH'(rr_next(32'(gnt_idx), NUM_QUEUES));
            count_d  = count_q + 32'd1;
        end else if (bus.rdy && (bus.flush || bus.issue_ready)) begin
            slot_d.valid = 1'b0;
        end
    end

    // slot, round-robin pointer and load counter; async reset drops any slot content
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_gelato_issue_arbiter.sv
// tb_gelato_issue_arbiter: vector table, handshake corner sequences and queue-model integration run
module tb_gelato_issue_arbiter;
    import gelato_issue_pkg::*;

    typedef struct {
        logic         rdy;
        logic         flush;
        logic [3:0]   empty;
        logic [3:0]   blocked;
        logic         ready;
        logic [3:0]   pop;
        logic         valid;
        issue_entry_t e;
        issue_qid_t   ptr;
        logic [31:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] td [4];

    gelato_issue_arbiter_if #(.NUM_QUEUES(4), .DATA_WIDTH(32)) bus ();

    gelato_issue_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_tail();
        bus.q_tail_data = {td[3], td[2], td[1], td[0]};
    endtask

    task automatic set_in(input logic r, input logic f, input logic [3:0] em, input logic [3:0] bl, input logic rd);
        bus.rdy         = r;
        bus.flush       = f;
        bus.q_empty     = em;
        bus.q_blocked   = bl;
        bus.issue_ready = rd;
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] em, input logic [3:0] bl,
                                input logic rd, input logic [3:0] p, input logic vl, input int q,
                                input logic [31:0] d, input int pt, input logic [31:0] c);
        vec_t t;
        t.rdy = r; t.flush = f; t.empty = em; t.blocked = bl; t.ready = rd;
        t.pop = p; t.valid = vl; t.e.qid = issue_qid_t'(q); t.e.data = d;
        t.ptr = issue_qid_t'(pt); t.cnt = c;
        return t;
    endfunction

    vec_t vecs [18];

    logic [31:0] fifo [4][$];
    logic [31:0] expq [4][$];

    initial begin
        int pushed = 0, issued = 0, pops = 0, seq = 0;
        logic done = 1'b0;
        logic [3:0] popv;

        vecs[0]  = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 32'h10, 1, 1);
        vecs[1]  = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 1, 32'h11, 2, 2);
        vecs[2]  = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b0100, 1, 2, 32'h12, 3, 3);
        vecs[3]  = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b1000, 1, 3, 32'h13, 0, 4);
        vecs[4]  = mk(1, 0, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 32'h10, 1, 5);
        vecs[5]  = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 32'h10, 1, 5);
        vecs[6]  = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 32'h10, 1, 5);
        vecs[7]  = mk(1, 0, 4'b0000, 4'b0010, 1, 4'b0100, 1, 2, 32'h12, 3, 6);
        vecs[8]  = mk(1, 0, 4'b0001, 4'b1000, 1, 4'b0010, 1, 1, 32'h11, 2, 7);
        vecs[9]  = mk(1, 0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 1, 32'h11, 2, 7);
        vecs[10] = mk(1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 1, 32'h11, 2, 7);
        vecs[11] = mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 32'h11, 2, 7);
        vecs[12] = mk(1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 32'h11, 2, 7);
        vecs[13] = mk(1, 0, 4'b0000, 4'b0000, 0, 4'b0100, 1, 2, 32'h12, 3, 8);
        vecs[14] = mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 2, 32'h12, 3, 8);
        vecs[15] = mk(1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2, 32'h12, 3, 8);
        vecs[16] = mk(1, 0, 4'b0111, 4'b0000, 1, 4'b1000, 1, 3, 32'h13, 0, 9);
        vecs[17] = mk(1, 0, 4'b0111, 4'b1000, 1, 4'b0000, 0, 3, 32'h13, 0, 9);

        for (int i = 0; i < 4; i++) td[i] = 32'h10 + i;
        drive_tail();
        set_in(1, 0, 4'b0000, 4'b0000, 1);
        rst_n = 1'b0;
        #12;
        chk("rst_pop", bus.q_pop, 4'b0000);
        chk("rst_valid", bus.issue_valid, 1'b0);
        chk("rst_data", bus.issue_data, 32'h0);
        chk("rst_qid", bus.issue_qid, 2'd0);
        chk("rst_count", bus.issue_count, 32'd0);
        chk("rst_ptr", dut.rr_ptr_q, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 18; k++) begin
            set_in(vecs[k].rdy, vecs[k].flush, vecs[k].empty, vecs[k].blocked, vecs[k].ready);
            #2;
            chk($sformatf("v%0d_pop", k), bus.q_pop, vecs[k].pop);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", k), bus.issue_valid, vecs[k].valid);
            if (vecs[k].valid) begin
                chk($sformatf("v%0d_qid", k), bus.issue_qid, vecs[k].e.qid);
                chk($sformatf("v%0d_data", k), bus.issue_data, vecs[k].e.data);
            end
            chk($sformatf("v%0d_ptr", k), dut.rr_ptr_q, vecs[k].ptr);
            chk($sformatf("v%0d_count", k), bus.issue_count, vecs[k].cnt);
        end

        td[0] = 32'hA5A5_0001;
        td[1] = 32'hA5A5_0002;
        drive_tail();
        set_in(1, 0, 4'b0000, 4'b0000, 0);
        @(posedge clk); #1;
        chk("bp_load_data", bus.issue_data, 32'hA5A5_0001);
        chk("bp_load_ptr", dut.rr_ptr_q, 2'd1);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("bp%0d_pop", c), bus.q_pop, 4'b0000);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c), bus.issue_valid, 1'b1);
            chk($sformatf("bp%0d_data", c), bus.issue_data, 32'hA5A5_0001);
            chk($sformatf("bp%0d_qid", c), bus.issue_qid, 2'd0);
        end
        bus.issue_ready = 1'b1;
        #2;
        chk("bp_release_pop", bus.q_pop, 4'b0010);
        @(posedge clk); #1;
        chk("bp_next_valid", bus.issue_valid, 1'b1);
        chk("bp_next_data", bus.issue_data, 32'hA5A5_0002);
        chk("bp_next_qid", bus.issue_qid, 2'd1);
        chk("bp_next_count", bus.issue_count, 32'd11);

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.issue_valid, 1'b0);
        chk("arst_ptr", dut.rr_ptr_q, 2'd0);
        chk("arst_count", bus.issue_count, 32'd0);
        chk("arst_pop", bus.q_pop, 4'b0000);
        @(posedge clk); #1;
        chk("arst_hold_pop", bus.q_pop, 4'b0000);
        rst_n = 1'b1;
        #2;
        chk("arst_release_pop", bus.q_pop, 4'b0001);
        @(posedge clk); #1;
        chk("arst_reload_data", bus.issue_data, 32'hA5A5_0001);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 800 && !done; cyc++) begin
            logic pushing;
            pushing = cyc < 400;
            if (pushing) begin
                for (int i = 0; i < 4; i++) begin
                    if (fifo[i].size() < 2 && $urandom_range(0, 1) == 1) begin
                        fifo[i].push_back({8'(i), 24'(seq)});
                        expq[i].push_back({8'(i), 24'(seq)});
                        seq++;
                        pushed++;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                bus.q_empty[i]   = fifo[i].size() == 0;
                td[i]            = (fifo[i].size() == 0) ? 32'hDEAD_0000 : fifo[i][0];
                bus.q_blocked[i] = pushing && $urandom_range(0, 3) == 0;
            end
            drive_tail();
            bus.issue_ready = !pushing || $urandom_range(0, 3) != 0;
            #2;
            popv = bus.q_pop;
            chk("int_pop_legal", {30'd0, $countones(popv) <= 1, (popv & bus.q_empty) == 4'b0000}, 64'd3);
            if (bus.issue_valid && bus.issue_ready) begin
                if (expq[bus.issue_qid].size() == 0) begin
                    chk("int_unexpected_issue", {32'd0, bus.issue_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("int_issue_order", bus.issue_data, expq[bus.issue_qid].pop_front());
                end
                issued++;
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (popv[i] && fifo[i].size() != 0) begin
                    void'(fifo[i].pop_front());
                    pops++;
                end
            end
            done = !pushing && !bus.issue_valid &&
                   fifo[0].size() == 0 && fifo[1].size() == 0 && fifo[2].size() == 0 && fifo[3].size() == 0;
        end
        chk("int_drained", done, 1'b1);
        chk("int_issued_eq_pushed", issued, pushed);
        chk("int_pops_eq_pushed", pops, pushed);
        chk("int_count_eq_pushed", bus.issue_count, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
